// File: rtl/tap_controller_pkg.sv
// rtl/tap_controller_pkg.sv - TAP state encodings, IR opcodes and strobe bundle type
`timescale 1ns/1ps
package tap_controller_pkg;

  // 16-state TAP encoding
  localparam logic [3:0] TAP_TLR    = 4'hF;
  localparam logic [3:0] TAP_RTI    = 4'hC;
  localparam logic [3:0] TAP_SEL_DR = 4'h7;
  localparam logic [3:0] TAP_CAP_DR = 4'h6;
  localparam logic [3:0] TAP_SH_DR  = 4'h2;
  localparam logic [3:0] TAP_EX1_DR = 4'h1;
  localparam logic [3:0] TAP_PAU_DR = 4'h3;
  localparam logic [3:0] TAP_EX2_DR = 4'h0;
  localparam logic [3:0] TAP_UPD_DR = 4'h5;
  localparam logic [3:0] TAP_SEL_IR = 4'h4;
  localparam logic [3:0] TAP_CAP_IR = 4'hE;
  localparam logic [3:0] TAP_SH_IR  = 4'hA;
  localparam logic [3:0] TAP_EX1_IR = 4'h9;
  localparam logic [3:0] TAP_PAU_IR = 4'hB;
  localparam logic [3:0] TAP_EX2_IR = 4'h8;
  localparam logic [3:0] TAP_UPD_IR = 4'hD;

  // 2-bit instruction register opcodes
  localparam logic [1:0] IR_EXTEST = 2'b00;
  localparam logic [1:0] IR_SAMPLE = 2'b01;
  localparam logic [1:0] IR_INTEST = 2'b10;
  localparam logic [1:0] IR_BYPASS = 2'b11;

  // Scan-chain control outputs produced by the strobe generator
  typedef struct packed {
    logic clockdr;
    logic shiftdr;
    logic updatedr;
    logic clockir;
    logic shiftir;
    logic updateir;
    logic tdo_sel;
    logic tdo_en;
  } tap_strobes_t;

  // True in the states where the DR chain receives a clock edge on exit
  function automatic logic is_dr_clk_state(input logic [3:0] s);
    return (s == TAP_CAP_DR) || (s == TAP_SH_DR);
  endfunction

  // True in the states where the IR receives a clock edge on exit
  function automatic logic is_ir_clk_state(input logic [3:0] s);
    return (s == TAP_CAP_IR) || (s == TAP_SH_IR);
  endfunction

endpackage

// File: rtl/tap_strobe_gen.sv
// rtl/tap_strobe_gen.sv - glitch-free capture/shift/update strobes derived from TAP state
`timescale 1ns/1ps
module tap_strobe_gen
  import tap_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               i_ck,
  input  logic               i_rst,
  input  logic [STATE_W-1:0] i_state,
  input  logic [STATE_W-1:0] i_next_state,
  output tap_strobes_t       o_strobes
);

  logic r_dr_clk_en;
  logic r_ir_clk_en;
  logic r_shiftdr;
  logic r_shiftir;
  logic r_tdo_en;
  logic r_tdo_sel;
  logic r_upd_dr_flag;
  logic r_upd_ir_flag;

  // Enables and shift levels move only while ck is low, so gating with ck cannot glitch
  always_ff @(negedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      r_dr_clk_en <= 1'b0;
      r_ir_clk_en <= 1'b0;
      r_shiftdr   <= 1'b0;
      r_shiftir   <= 1'b0;
      r_tdo_en    <= 1'b0;
      r_tdo_sel   <= 1'b0;
    end else begin
      r_dr_clk_en <= is_dr_clk_state(i_state);
      r_ir_clk_en <= is_ir_clk_state(i_state);
      r_shiftdr   <= (i_state == TAP_SH_DR);
      r_shiftir   <= (i_state == TAP_SH_IR);
      r_tdo_en    <= (i_state == TAP_SH_DR) || (i_state == TAP_SH_IR);
      // Mux follows the active shift; outside shifting it keeps its last source
      if (i_state == TAP_SH_IR) begin
        r_tdo_sel <= 1'b1;
      end else if (i_state == TAP_SH_DR) begin
        r_tdo_sel <= 1'b0;
      end
    end
  end

  // Update flags move only while ck is high; set on the edge that enters UPD_x
  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      r_upd_dr_flag <= 1'b0;
      r_upd_ir_flag <= 1'b0;
    end else begin
      r_upd_dr_flag <= (i_next_state == TAP_UPD_DR);
      r_upd_ir_flag <= (i_next_state == TAP_UPD_IR);
    end
  end

  assign o_strobes.clockdr  = i_ck & r_dr_clk_en;
  assign o_strobes.clockir  = i_ck & r_ir_clk_en;
  assign o_strobes.updatedr = ~i_ck & r_upd_dr_flag;
  assign o_strobes.updateir = ~i_ck & r_upd_ir_flag;
  assign o_strobes.shiftdr  = r_shiftdr;
  assign o_strobes.shiftir  = r_shiftir;
  assign o_strobes.tdo_en   = r_tdo_en;
  assign o_strobes.tdo_sel  = r_tdo_sel;

endmodule

// File: rtl/tap_controller.sv
// rtl/tap_controller.sv - 16-state JTAG TAP controller with scan-chain strobes
`timescale 1ns/1ps
module tap_controller
  import tap_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               ck,
  input  logic               reset,
  input  logic               TMS,
  output logic               clockdr,
  output logic               shiftdr,
  output logic               updatedr,
  output logic               clockir,
  output logic               shiftir,
  output logic               updateir,
  output logic               tlr,
  output logic               tdo_sel,
  output logic               tdo_en,
  output logic [STATE_W-1:0] tap_state
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  tap_strobes_t       w_strobes;

  // Next-state decode of TMS for every TAP state
  always_comb begin
    w_next_state = TAP_TLR;
    case (r_state)
      TAP_TLR:    w_next_state = TMS ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    w_next_state = TMS ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: w_next_state = TMS ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: w_next_state = TMS ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  w_next_state = TMS ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: w_next_state = TMS ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: w_next_state = TMS ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: w_next_state = TMS ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: w_next_state = TMS ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: w_next_state = TMS ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: w_next_state = TMS ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  w_next_state = TMS ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: w_next_state = TMS ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: w_next_state = TMS ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: w_next_state = TMS ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: w_next_state = TMS ? TAP_SEL_DR : TAP_RTI;
      default:    w_next_state = TAP_TLR;
    endcase
  end

  // State register; reset parks the controller in TEST_LOGIC_RESET
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_state <= TAP_TLR;
    end else begin
      r_state <= w_next_state;
    end
  end

  tap_strobe_gen #(
    .STATE_W(STATE_W)
  ) u_strobe_gen (
    .i_ck         (ck),
    .i_rst        (reset),
    .i_state      (r_state),
    .i_next_state (w_next_state),
    .o_strobes    (w_strobes)
  );

  assign clockdr   = w_strobes.clockdr;
  assign shiftdr   = w_strobes.shiftdr;
  assign updatedr  = w_strobes.updatedr;
  assign clockir   = w_strobes.clockir;
  assign shiftir   = w_strobes.shiftir;
  assign updateir  = w_strobes.updateir;
  assign tdo_sel   = w_strobes.tdo_sel;
  assign tdo_en    = w_strobes.tdo_en;
  assign tlr       = (r_state == TAP_TLR);
  assign tap_state = r_state;

endmodule

// File: tb/tb_tap_controller.sv
// tb/tb_tap_controller.sv - self-checking bench for tap_controller
`timescale 1ns/1ps
module tb_tap_controller;

  logic       ck = 1'b0;
  logic       reset;
  logic       TMS;
  logic       TDI;
  logic       clockdr, shiftdr, updatedr, clockir, shiftir, updateir;
  logic       tlr, tdo_sel, tdo_en;
  logic [3:0] tap_state;

  tap_controller #(.STATE_W(4)) dut (
    .ck        (ck),
    .reset     (reset),
    .TMS       (TMS),
    .clockdr   (clockdr),
    .shiftdr   (shiftdr),
    .updatedr  (updatedr),
    .clockir   (clockir),
    .shiftir   (shiftir),
    .updateir  (updateir),
    .tlr       (tlr),
    .tdo_sel   (tdo_sel),
    .tdo_en    (tdo_en),
    .tap_state (tap_state)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: controller position as (phase, which branch)
  typedef enum int {P_TLR, P_RTI, P_SEL, P_CAP, P_SH, P_EX1, P_PAU, P_EX2, P_UPD} phase_t;
  phase_t m_ph, m_prev_ph;
  bit     m_ir, m_prev_ir;

  function automatic logic [3:0] enc(input phase_t p, input bit ir);
    case (p)
      P_TLR:   return 4'hF;
      P_RTI:   return 4'hC;
      P_SEL:   return ir ? 4'h4 : 4'h7;
      P_CAP:   return ir ? 4'hE : 4'h6;
      P_SH:    return ir ? 4'hA : 4'h2;
      P_EX1:   return ir ? 4'h9 : 4'h1;
      P_PAU:   return ir ? 4'hB : 4'h3;
      P_EX2:   return ir ? 4'h8 : 4'h0;
      default: return ir ? 4'hD : 4'h5;
    endcase
  endfunction

  task automatic model_step(input logic tms);
    case (m_ph)
      P_TLR: begin m_ph = tms ? P_TLR : P_RTI; m_ir = 0; end
      P_RTI: if (tms) begin m_ph = P_SEL; m_ir = 0; end
      P_SEL: if (!tms) m_ph = P_CAP;
             else if (!m_ir) m_ir = 1;
             else begin m_ph = P_TLR; m_ir = 0; end
      P_CAP, P_SH: m_ph = tms ? P_EX1 : P_SH;
      P_EX1: m_ph = tms ? P_UPD : P_PAU;
      P_PAU: m_ph = tms ? P_EX2 : P_PAU;
      P_EX2: m_ph = tms ? P_UPD : P_SH;
      default: if (tms) begin m_ph = P_SEL; m_ir = 0; end else m_ph = P_RTI;
    endcase
  endtask

  task automatic model_reset();
    m_ph = P_TLR; m_ir = 0; m_prev_ph = P_TLR; m_prev_ir = 0;
  endtask

  // Scan cells driven by the controller: 4-cell DR chain and 2-bit IR
  logic [3:0] dr_chain = 4'h0, dr_upd = 4'h0;
  logic [1:0] ir_sr = 2'b00, ir_inst = 2'b00;
  int n_clkdr = 0, n_clkir = 0, n_upddr = 0, n_updir = 0, n_sh_cyc = 0;
  realtime t_dr_rise, t_ud_rise;

  always @(posedge clockdr) begin
    n_clkdr++;
    t_dr_rise = $realtime;
    dr_chain <= shiftdr ? {TDI, dr_chain[3:1]} : 4'b0101;
  end
  always @(negedge clockdr) if (!reset) chk("clockdr_width", ($realtime - t_dr_rise) >= 5.0, 1);
  always @(posedge updatedr) begin
    n_upddr++;
    t_ud_rise = $realtime;
    dr_upd <= dr_chain;
  end
  always @(negedge updatedr) if (!reset) chk("updatedr_width", ($realtime - t_ud_rise) >= 5.0, 1);
  always @(posedge clockir) begin
    n_clkir++;
    ir_sr <= shiftir ? {TDI, ir_sr[1]} : 2'b01;
  end
  always @(posedge updateir) begin
    n_updir++;
    ir_inst <= ir_sr;
  end

  // One TCK cycle: drive while ck low, check after the rising and after the falling edge
  task automatic cycle(input logic tms, input logic tdi);
    bit dr_ctl, ir_ctl;
    TMS = tms;
    TDI = tdi;
    @(posedge ck);
    m_prev_ph = m_ph;
    m_prev_ir = m_ir;
    model_step(tms);
    #1;
    chk("tap_state", tap_state, enc(m_ph, m_ir));
    chk("tlr", tlr, m_ph == P_TLR);
    chk("clockdr_hi", clockdr, (m_prev_ph == P_CAP || m_prev_ph == P_SH) && !m_prev_ir);
    chk("clockir_hi", clockir, (m_prev_ph == P_CAP || m_prev_ph == P_SH) && m_prev_ir);
    chk("updatedr_hi", updatedr, 0);
    chk("updateir_hi", updateir, 0);
    @(negedge ck);
    #1;
    chk("shiftdr", shiftdr, m_ph == P_SH && !m_ir);
    chk("shiftir", shiftir, m_ph == P_SH && m_ir);
    chk("tdo_en", tdo_en, m_ph == P_SH);
    chk("updatedr_lo", updatedr, m_ph == P_UPD && !m_ir);
    chk("updateir_lo", updateir, m_ph == P_UPD && m_ir);
    chk("clockdr_lo", clockdr, 0);
    chk("clockir_lo", clockir, 0);
    if (m_ph == P_SH && m_ir) chk("tdo_sel_ir", tdo_sel, 1);
    dr_ctl = shiftdr | updatedr;
    ir_ctl = shiftir | updateir;
    chk("dr_ir_exclusive", dr_ctl & ir_ctl, 0);
    if (shiftdr) n_sh_cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, tap_state, 4'hF);
    chk({tag, "_tlr"}, tlr, 1);
    chk({tag, "_strobes"}, {clockdr, clockir, updatedr, updateir, shiftdr, shiftir, tdo_en, tdo_sel}, 8'h00);
  endtask

  // Asynchronous reset from the current state, at a random point of the cycle
  task automatic do_reset(input string tag);
    int d;
    d = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 2) : $urandom_range(5, 7);
    #(d);
    reset = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(negedge ck);
    #1;
    check_reset_outputs({tag, "_held"});
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int n0, u0, s0, i0, p0;
    reset = 1'b1;
    TMS   = 1'b0;
    TDI   = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge ck);
    #1;
    reset = 1'b0;

    // DR scan: capture + 4 shifts of 1011, single update, back to RTI
    n0 = n_clkdr; u0 = n_upddr; s0 = n_sh_cyc; i0 = n_clkir;
    cycle(0, 0); cycle(1, 0); cycle(0, 0); cycle(0, 0);
    cycle(0, 1); cycle(0, 1); cycle(0, 0); cycle(1, 1);
    cycle(1, 0); cycle(0, 0);
    chk("dr_clk_edges", n_clkdr - n0, 5);
    chk("dr_shift_cycles", n_sh_cyc - s0, 4);
    chk("dr_update_pulses", n_upddr - u0, 1);
    chk("dr_no_ir_clk", n_clkir - i0, 0);
    chk("dr_end_rti", tap_state, 4'hC);
    chk("dr_data", dr_upd, 4'b1011);

    // IR scan: capture + 2 shifts of 10
    do_reset("rst_ir");
    n0 = n_clkdr; u0 = n_updir; i0 = n_clkir;
    cycle(0, 0); cycle(1, 0); cycle(1, 0); cycle(0, 0); cycle(0, 0);
    cycle(0, 0); cycle(1, 1); cycle(1, 0); cycle(0, 0);
    chk("ir_clk_edges", n_clkir - i0, 3);
    chk("ir_no_dr_clk", n_clkdr - n0, 0);
    chk("ir_update_pulses", n_updir - u0, 1);
    chk("ir_inst", ir_inst, 2'b10);
    chk("ir_tdo_sel", tdo_sel, 1);

    // DR scan with a pause excursion in the middle
    n0 = n_clkdr;
    cycle(1, 0); cycle(0, 0); cycle(0, 0); cycle(0, 0); cycle(1, 1);
    p0 = n_clkdr;
    cycle(0, 0); cycle(0, 0); cycle(0, 0); cycle(1, 0); cycle(0, 0);
    chk("pause_no_clk", n_clkdr - p0, 0);
    cycle(0, 1); cycle(1, 0); cycle(1, 0); cycle(0, 0);
    chk("pause_clk_edges", n_clkdr - n0, 5);
    chk("pause_data", dr_upd, 4'b0110);

    // Worst-case distance to TLR is five TMS=1 edges (from PAU_DR)
    cycle(1, 0); cycle(0, 0); cycle(1, 0); cycle(0, 0);
    repeat (4) cycle(1, 0);
    chk("four_ones_not_tlr", tlr, 0);
    cycle(1, 0);
    chk("five_ones_tlr", tlr, 1);

    // Reset asserted while shifting DR
    cycle(0, 0); cycle(1, 0); cycle(0, 0); cycle(0, 0); cycle(0, 1);
    TMS = 1'b0;
    @(posedge ck);
    #1;
    chk("midshift_clockdr_pre", clockdr, 1);
    u0 = n_upddr;
    reset = 1'b1;
    #1;
    chk("midshift_clockdr", clockdr, 0);
    chk("midshift_shiftdr", shiftdr, 0);
    chk("midshift_tdo_en", tdo_en, 0);
    chk("midshift_state", tap_state, 4'hF);
    @(negedge ck);
    #1;
    chk("midshift_updatedr", updatedr, 0);
    @(posedge ck);
    #1;
    chk("midshift_clockdr_held", clockdr, 0);
    @(negedge ck);
    #1;
    chk("midshift_no_update", n_upddr - u0, 0);
    reset = 1'b0;
    model_reset();

    // Random TMS/TDI walk with periodic five-ones and reset checks
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (i % 50 == 49) begin
        repeat (5) cycle(1, 0);
        chk("rand_five_ones", tap_state, 4'hF);
      end
      if (i % 70 == 69) do_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
